wide_alu_seq: RTL

Multi-cycle sequencer that executes 16-bit operations on the existing 8-bit combinational ALU. It is the driving end of the ALU interface: it generates the ALU operands and opcode and consumes the ALU result and zero flag. It sits between the datapath's 16-bit operation requester and the ALU. Each request is split into byte-wise ALU operations, and carries are derived with the ALU overflow-check opcode.

---
 rtl/wide_alu_seq.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/wide_alu_seq.sv
// wide_alu_seq: runs 16-bit AND/ADD/XOR/LT/NE requests as a sequence of byte-wide
// operations on an external 8-bit combinational ALU.
// Optional macro WIDE_ALU_CARRY_OUT_EN: adds resp_carry and two carry-out steps to ADD.
module wide_alu_seq #(
`ifdef WIDE_ALU_CARRY_OUT_EN
  parameter int ADD_STEPS = 6
`else
  parameter int ADD_STEPS = 4
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic        resp_zero,
  output logic        resp_err,
`ifdef WIDE_ALU_CARRY_OUT_EN
  output logic        resp_carry,
`endif
  output logic [7:0]  alu_input_a,
  output logic [7:0]  alu_input_b,
  output logic [2:0]  alu_opcode,
  input  logic [7:0]  alu_out,
  input  logic        zero
);

`ifdef WIDE_ALU_CARRY_OUT_EN
  localparam int STEP_W = 3;
`else
  localparam int STEP_W = 2;
`endif

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_LT  = 3'b011;
  localparam logic [2:0] OP_NE  = 3'b110;
  localparam logic [2:0] OP_OVF = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t              state_q;
  logic [STEP_W-1:0]   step_q;
  logic [2:0]          op_q;
  logic [15:0]         a_q, b_q;
  logic [7:0]          res_lo_q, tmp_q;
  logic                carry_q, lt_hi_q, ne_hi_q;
  logic                resp_valid_q, resp_zero_q, resp_err_q;
  logic [15:0]         resp_data_q;
  logic                last_step;
  logic [15:0]         resp_data_d;
`ifdef WIDE_ALU_CARRY_OUT_EN
  logic [7:0]          res_hi_q;
  logic                c1_q, resp_carry_q, resp_carry_d;
`endif

  // The ALU zero flag is not needed: resp_zero is derived from the full 16-bit result.
  logic unused_zero;
  assign unused_zero = zero;

  function automatic logic op_supported(input logic [2:0] op);
    return op inside {OP_AND, OP_ADD, OP_XOR, OP_LT, OP_NE};
  endfunction

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_zero  = resp_zero_q;
  assign resp_err   = resp_err_q;
`ifdef WIDE_ALU_CARRY_OUT_EN
  assign resp_carry = resp_carry_q;
`endif

  // ALU drive for the current step plus the final result formed from this cycle's alu_out.
  always_comb begin
    alu_input_a = 8'h00;
    alu_input_b = 8'h00;
    alu_opcode  = OP_AND;
    last_step   = 1'b0;
    resp_data_d = 16'h0000;
`ifdef WIDE_ALU_CARRY_OUT_EN
    resp_carry_d = 1'b0;
`endif
    if (state_q == S_EXEC) begin
      case (op_q)
        OP_AND, OP_XOR, OP_NE: begin
          alu_opcode  = op_q;
          alu_input_a = (step_q == STEP_W'(0)) ? a_q[7:0] : a_q[15:8];
          alu_input_b = (step_q == STEP_W'(0)) ? b_q[7:0] : b_q[15:8];
          last_step   = (step_q == STEP_W'(1));
          if (op_q == OP_NE) resp_data_d = {15'b0, res_lo_q[0] | alu_out[0]};
          else               resp_data_d = {alu_out, res_lo_q};
        end
        OP_LT: begin
          alu_opcode  = (step_q == STEP_W'(1)) ? OP_NE : OP_LT;
          alu_input_a = (step_q == STEP_W'(2)) ? a_q[7:0] : a_q[15:8];
          alu_input_b = (step_q == STEP_W'(2)) ? b_q[7:0] : b_q[15:8];
          last_step   = (step_q == STEP_W'(2));
          // High bytes decide unless they are equal.
          resp_data_d = {15'b0, ne_hi_q ? lt_hi_q : alu_out[0]};
        end
        OP_ADD: begin
          if (step_q == STEP_W'(0)) begin
            alu_opcode = OP_ADD; alu_input_a = a_q[7:0];  alu_input_b = b_q[7:0];
          end else if (step_q == STEP_W'(1)) begin
            alu_opcode = OP_OVF; alu_input_a = a_q[7:0];  alu_input_b = b_q[7:0];
          end else if (step_q == STEP_W'(2)) begin
            alu_opcode = OP_ADD; alu_input_a = a_q[15:8]; alu_input_b = b_q[15:8];
`ifdef WIDE_ALU_CARRY_OUT_EN
          end else if (step_q == STEP_W'(3)) begin
            alu_opcode = OP_ADD; alu_input_a = tmp_q;     alu_input_b = {7'b0, carry_q};
          end else if (step_q == STEP_W'(4)) begin
            alu_opcode = OP_OVF; alu_input_a = a_q[15:8]; alu_input_b = b_q[15:8];
          end else begin
            alu_opcode = OP_OVF; alu_input_a = tmp_q;     alu_input_b = {7'b0, carry_q};
          end
          resp_data_d  = {res_hi_q, res_lo_q};
          resp_carry_d = c1_q | alu_out[0];
`else
          end else begin
            alu_opcode = OP_ADD; alu_input_a = tmp_q;     alu_input_b = {7'b0, carry_q};
          end
          resp_data_d = {alu_out, res_lo_q};
`endif
          last_step = (step_q == STEP_W'(ADD_STEPS - 1));
        end
        default: ;
      endcase
    end
  end

  // Control FSM: accept, step through ALU ops capturing partials, hold the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      step_q       <= '0;
      op_q         <= 3'b000;
      a_q          <= 16'h0000;
      b_q          <= 16'h0000;
      res_lo_q     <= 8'h00;
      tmp_q        <= 8'h00;
      carry_q      <= 1'b0;
      lt_hi_q      <= 1'b0;
      ne_hi_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 16'h0000;
      resp_zero_q  <= 1'b0;
      resp_err_q   <= 1'b0;
`ifdef WIDE_ALU_CARRY_OUT_EN
      res_hi_q     <= 8'h00;
      c1_q         <= 1'b0;
      resp_carry_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            a_q    <= req_a;
            b_q    <= req_b;
            step_q <= '0;
            if (op_supported(req_op)) begin
              state_q <= S_EXEC;
            end else begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_data_q  <= 16'h0000;
              resp_zero_q  <= 1'b1;
              resp_err_q   <= 1'b1;
`ifdef WIDE_ALU_CARRY_OUT_EN
              resp_carry_q <= 1'b0;
`endif
            end
          end
        end
        S_EXEC: begin
          step_q <= step_q + STEP_W'(1);
          case (op_q)
            OP_AND, OP_XOR, OP_NE: if (step_q == STEP_W'(0)) res_lo_q <= alu_out;
            OP_LT: begin
              if (step_q == STEP_W'(0)) lt_hi_q <= alu_out[0];
              if (step_q == STEP_W'(1)) ne_hi_q <= alu_out[0];
            end
            OP_ADD: begin
              if (step_q == STEP_W'(0)) res_lo_q <= alu_out;
              if (step_q == STEP_W'(1)) carry_q  <= alu_out[0];
              if (step_q == STEP_W'(2)) tmp_q    <= alu_out;
`ifdef WIDE_ALU_CARRY_OUT_EN
              if (step_q == STEP_W'(3)) res_hi_q <= alu_out;
              if (step_q == STEP_W'(4)) c1_q     <= alu_out[0];
`endif
            end
            default: ;
          endcase
          if (last_step) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_data_q  <= resp_data_d;
            resp_zero_q  <= (resp_data_d == 16'h0000);
            resp_err_q   <= 1'b0;
`ifdef WIDE_ALU_CARRY_OUT_EN
            resp_carry_q <= resp_carry_d;
`endif
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
